uart_echo_checker: RTL and testbench

- Synthesizable self-checking serial loopback exerciser. It sends NUM_BYTES generated bytes into a UART transmit handshake and compares every echoed byte against the expected value.
- Generalises the single-byte echo check to N bytes, two pattern modes, pipelined outstanding bytes, error capture and a timeout.
- Sits beside the off-chip `uart` instance. Usable in simulation benches and as on-FPGA BIST driven by switches/LEDs.

---
 rtl/uart_echo_pkg.sv | 28 ++
 rtl/echo_expect_fifo.sv | 67 ++++++
 rtl/uart_echo_checker.sv | 188 ++++++++++++++++++
 tb/tb_uart_echo_checker.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_echo_pkg.sv
// Shared types and pattern generator for the uart echo checker.
package uart_echo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Galois form of x^8+x^6+x^5+x^4+1, right-shifting
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [31:0] next_pattern(input logic        mode,
                                                input logic [31:0] value,
                                                input int unsigned width);
      logic [31:0] nxt;
      logic [31:0] mask;
      if (mode) begin
         nxt = (value >> 1) ^ (value[0] ? {24'd0, LFSR_TAPS} : 32'd0);
      end else begin
         nxt = value + 32'd1;
      end
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return nxt & mask;
   endfunction

endpackage

// File: rtl/echo_expect_fifo.sv
// Expected-value FIFO: holds bytes sent but not yet echoed. Read data is the
// registered head entry, so an entry is poppable one cycle after its push.
module echo_expect_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH) + 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (do_push && !do_pop) begin
            count <= count + CW'(1);
         end else if (!do_push && do_pop) begin
            count <= count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/uart_echo_checker.sv
// Loopback exerciser: streams generated bytes into a uart transmit handshake and
// checks every echoed byte against a FIFO of expected values.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | issuing bytes and checking echoes
// DRAIN | all bytes issued, waiting for the remaining echoes
// DONE  | results held; start re-arms a new run
module uart_echo_checker
   import uart_echo_pkg::*;
#(
   parameter int DATA_WIDTH      = 8,
   parameter int NUM_BYTES       = 16,
   parameter int MAX_OUTSTANDING = 4,
   parameter int PATTERN_MODE    = 0,
   parameter int TIMEOUT_CYCLES  = 1_000_000
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] seed,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  timeout,
   output logic [15:0]           error_count,
   output logic [15:0]           first_err_index,
   output logic [DATA_WIDTH-1:0] first_err_got,
   output logic [DATA_WIDTH-1:0] first_err_exp
);

   localparam int OW        = $clog2(MAX_OUTSTANDING) + 1;
   localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam bit MODE_LFSR = (PATTERN_MODE != 0);

   state_t                state;
   state_t                state_nxt;
   logic [DATA_WIDTH-1:0] gen;
   logic [DATA_WIDTH-1:0] gen_next;
   logic [DATA_WIDTH-1:0] seed_eff;
   logic [15:0]           sent;
   logic [15:0]           received;
   logic [TW-1:0]         tmo_cnt;

   logic                  fifo_full;
   logic                  fifo_empty;
   logic [OW-1:0]         fifo_count;
   logic [DATA_WIDTH-1:0] fifo_dout;

   logic                  running;
   logic                  start_ok;
   logic                  tx_fire;
   logic                  rx_fire;
   logic                  mismatch;
   logic                  outstanding;
   logic                  tmo_hit;

   assign running     = (state == RUN) || (state == DRAIN);
   assign start_ok    = start && ((state == IDLE) || (state == DONE));
   assign outstanding = (fifo_count != '0);

   assign tx_data  = gen;
   assign tx_valid = (state == RUN) && (sent < 16'(NUM_BYTES)) && !fifo_full;
   assign tx_fire  = tx_valid && tx_ready;
   assign rx_ready = running && !fifo_empty;
   assign rx_fire  = rx_valid && rx_ready;
   assign mismatch = rx_fire && (rx_data != fifo_dout);
   assign tmo_hit  = running && outstanding && !rx_fire &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   // An all-zero LFSR state would lock up, so it is replaced by 1
   assign seed_eff = (MODE_LFSR && (seed == '0)) ? DATA_WIDTH'(1) : seed;
   assign gen_next = DATA_WIDTH'(next_pattern(MODE_LFSR, 32'(gen), DATA_WIDTH));

   assign pass = done && (error_count == 16'd0) && !timeout;

   echo_expect_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (MAX_OUTSTANDING)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (start_ok),
      .push  (tx_fire),
      .pop   (rx_fire),
      .din   (gen),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (tmo_hit) begin
               state_nxt = DONE;
            end else if (sent == 16'(NUM_BYTES)) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (tmo_hit || (received == 16'(NUM_BYTES))) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gen             <= '0;
         sent            <= '0;
         received        <= '0;
         tmo_cnt         <= '0;
         timeout         <= 1'b0;
         error_count     <= '0;
         first_err_index <= '0;
         first_err_got   <= '0;
         first_err_exp   <= '0;
      end else if (start_ok) begin
         gen             <= seed_eff;
         sent            <= '0;
         received        <= '0;
         tmo_cnt         <= '0;
         timeout         <= 1'b0;
         error_count     <= '0;
         first_err_index <= '0;
         first_err_got   <= '0;
         first_err_exp   <= '0;
      end else begin
         if (tx_fire) begin
            gen  <= gen_next;
            sent <= sent + 16'd1;
         end
         if (rx_fire) begin
            received <= received + 16'd1;
         end
         // error_count is still zero on the first mismatch of a run
         if (mismatch) begin
            if (error_count != 16'hFFFF) begin
               error_count <= error_count + 16'd1;
            end
            if (error_count == 16'd0) begin
               first_err_index <= received;
               first_err_got   <= rx_data;
               first_err_exp   <= fifo_dout;
            end
         end
         if (rx_fire) begin
            tmo_cnt <= '0;
         end else if (running && outstanding) begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end
         if (tmo_hit) begin
            timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_echo_checker.sv
// Directed bench: two checkers (incrementing and LFSR pattern) each looped back
// through a behavioural echo model with configurable delay and faults.
module tb_uart_echo_checker;

   localparam int NB  = 16;
   localparam int MO  = 4;
   localparam int TMO = 2000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       start_a, tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a;
   logic       busy_a, done_a, pass_a, timeout_a;
   logic [7:0] seed_a, tx_data_a, rx_data_a, feg_a, fee_a;
   logic [15:0] error_count_a, fei_a;

   logic       start_b, tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b;
   logic       busy_b, done_b, pass_b, timeout_b;
   logic [7:0] seed_b, tx_data_b, rx_data_b, feg_b, fee_b;
   logic [15:0] error_count_b, fei_b;

   uart_echo_checker #(
      .DATA_WIDTH(8), .NUM_BYTES(NB), .MAX_OUTSTANDING(MO),
      .PATTERN_MODE(0), .TIMEOUT_CYCLES(TMO)
   ) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .seed(seed_a),
      .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
      .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(timeout_a),
      .error_count(error_count_a), .first_err_index(fei_a),
      .first_err_got(feg_a), .first_err_exp(fee_a)
   );

   uart_echo_checker #(
      .DATA_WIDTH(8), .NUM_BYTES(NB), .MAX_OUTSTANDING(MO),
      .PATTERN_MODE(1), .TIMEOUT_CYCLES(TMO)
   ) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .seed(seed_b),
      .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
      .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(timeout_b),
      .error_count(error_count_b), .first_err_index(fei_b),
      .first_err_got(feg_b), .first_err_exp(fee_b)
   );

   typedef struct {
      logic [7:0] data;
      int         due;
   } echo_t;

   echo_t      q_a[$];
   echo_t      q_b[$];
   logic [7:0] log_a [NB];
   logic [7:0] log_b [NB];
   int cyc = 0;
   int push_a, pop_a, max_occ_a, last_acc_a, first_push_a, last_push_a;
   int push_b;
   int echo_delay, xor_idx, drop_idx;
   int checks = 0;
   int errors = 0;

   // Echo model: observe handshakes at the clock edge, present rx on the falling edge
   always @(posedge clk) begin
      echo_t e;
      cyc++;
      if (!rst || (start_a && !busy_a)) begin
         q_a.delete();
         push_a    = 0;
         pop_a     = 0;
         max_occ_a = 0;
      end else begin
         if (rx_valid_a && rx_ready_a) begin
            q_a.delete(0);
            pop_a++;
            last_acc_a = cyc;
         end
         if (tx_valid_a && tx_ready_a) begin
            if (push_a < NB) log_a[push_a] = tx_data_a;
            if (push_a == 0) first_push_a = cyc;
            last_push_a = cyc;
            e.data = tx_data_a ^ ((push_a == xor_idx) ? 8'h04 : 8'h00);
            e.due  = cyc + echo_delay;
            if (push_a != drop_idx) q_a.push_back(e);
            push_a++;
         end
         if (push_a - pop_a > max_occ_a) max_occ_a = push_a - pop_a;
      end
      if (!rst || (start_b && !busy_b)) begin
         q_b.delete();
         push_b = 0;
      end else begin
         if (rx_valid_b && rx_ready_b) q_b.delete(0);
         if (tx_valid_b && tx_ready_b) begin
            if (push_b < NB) log_b[push_b] = tx_data_b;
            e.data = tx_data_b;
            e.due  = cyc;
            q_b.push_back(e);
            push_b++;
         end
      end
   end

   always @(negedge clk) begin
      if (rst && q_a.size() > 0 && q_a[0].due <= cyc) begin
         rx_valid_a = 1'b1;
         rx_data_a  = q_a[0].data;
      end else begin
         rx_valid_a = 1'b0;
         rx_data_a  = 8'h00;
      end
      if (rst && q_b.size() > 0) begin
         rx_valid_b = 1'b1;
         rx_data_b  = q_b[0].data;
      end else begin
         rx_valid_b = 1'b0;
         rx_data_b  = 8'h00;
      end
   end

   task automatic pulse_start_a(input logic [7:0] s);
      @(negedge clk);
      seed_a  = s;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic pulse_start_b(input logic [7:0] s);
      @(negedge clk);
      seed_b  = s;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
   endtask

   task automatic wait_done_a(input int budget, output int at_cyc, output bit ok);
      ok = 1'b0;
      at_cyc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_a) begin
            ok = 1'b1;
            at_cyc = cyc;
            break;
         end
      end
   endtask

   task automatic wait_done_b(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_b) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic set_echo(input int dly, input int xi, input int di);
      echo_delay = dly;
      xor_idx    = xi;
      drop_idx   = di;
   endtask

   task automatic test_reset;
      logic [61:0] obs;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      obs = {tx_valid_a, rx_ready_a, busy_a, done_a, pass_a, timeout_a,
             error_count_a, fei_a, feg_a, fee_a, tx_data_a};
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL reset_a outputs got %h want 0", obs);
      end
      obs = {tx_valid_b, rx_ready_b, busy_b, done_b, pass_b, timeout_b,
             error_count_b, fei_b, feg_b, fee_b, tx_data_b};
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL reset_b outputs got %h want 0", obs);
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy_a, done_a, tx_valid_a} !== 3'b000) begin
         errors++;
         $display("FAIL idle_after_reset got %b want 000", {busy_a, done_a, tx_valid_a});
      end
   endtask

   task automatic test_incrementing;
      int t;
      bit ok;
      set_echo(0, -1, -1);
      pulse_start_a(8'h10);
      wait_done_a(1000, t, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL incr_done got 0 want 1"); end
      checks++;
      if ({pass_a, timeout_a, error_count_a} !== {1'b1, 1'b0, 16'd0}) begin
         errors++;
         $display("FAIL incr_result pass=%b timeout=%b err=%0d want 1 0 0", pass_a, timeout_a, error_count_a);
      end
      for (int i = 0; i < NB; i++) begin
         checks++;
         if (log_a[i] !== 8'(8'h10 + i)) begin
            errors++;
            $display("FAIL incr_byte[%0d] got %h want %h", i, log_a[i], 8'(8'h10 + i));
         end
      end
   endtask

   task automatic test_wrap;
      int t;
      bit ok;
      set_echo(0, -1, -1);
      pulse_start_a(8'hF8);
      wait_done_a(1000, t, ok);
      checks++;
      if (!ok || pass_a !== 1'b1) begin
         errors++;
         $display("FAIL wrap_pass got done=%b pass=%b want 1 1", done_a, pass_a);
      end
      checks++;
      if ({log_a[7], log_a[8], log_a[15]} !== {8'hFF, 8'h00, 8'h07}) begin
         errors++;
         $display("FAIL wrap_bytes got %h %h %h want ff 00 07", log_a[7], log_a[8], log_a[15]);
      end
   endtask

   task automatic test_lfsr;
      logic [7:0] hand [7];
      logic [7:0] saved [NB];
      bit ok;
      hand = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1};
      pulse_start_b(8'h00);
      wait_done_b(1000, ok);
      checks++;
      if (!ok || pass_b !== 1'b1 || error_count_b !== 16'd0) begin
         errors++;
         $display("FAIL lfsr_seed0_pass got done=%b pass=%b err=%0d want 1 1 0", done_b, pass_b, error_count_b);
      end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (log_b[i] !== hand[i]) begin
            errors++;
            $display("FAIL lfsr_byte[%0d] got %h want %h", i, log_b[i], hand[i]);
         end
      end
      saved = log_b;
      pulse_start_b(8'h01);
      wait_done_b(1000, ok);
      checks++;
      if (!ok || pass_b !== 1'b1) begin
         errors++;
         $display("FAIL lfsr_seed1_pass got done=%b pass=%b want 1 1", done_b, pass_b);
      end
      for (int i = 0; i < NB; i++) begin
         checks++;
         if (log_b[i] !== saved[i]) begin
            errors++;
            $display("FAIL lfsr_seed_equiv[%0d] got %h want %h", i, log_b[i], saved[i]);
         end
      end
   endtask

   task automatic test_mismatch;
      int t;
      bit ok;
      set_echo(0, 5, -1);
      pulse_start_a(8'h10);
      wait_done_a(1000, t, ok);
      checks++;
      if (!ok || {pass_a, timeout_a} !== 2'b00) begin
         errors++;
         $display("FAIL mism_flags got done=%b pass=%b timeout=%b want 1 0 0", done_a, pass_a, timeout_a);
      end
      checks++;
      if ({error_count_a, fei_a, fee_a, feg_a} !== {16'd1, 16'd5, 8'h15, 8'h11}) begin
         errors++;
         $display("FAIL mism_capture got cnt=%0d idx=%0d exp=%h got=%h want 1 5 15 11",
                  error_count_a, fei_a, fee_a, feg_a);
      end
   endtask

   task automatic test_timeout;
      int t;
      bit ok;
      set_echo(0, -1, 9);
      pulse_start_a(8'h10);
      wait_done_a(5000, t, ok);
      checks++;
      if (!ok || {timeout_a, pass_a} !== 2'b10) begin
         errors++;
         $display("FAIL tmo_flags got done=%b timeout=%b pass=%b want 1 1 0", done_a, timeout_a, pass_a);
      end
      checks++;
      if (t - last_acc_a !== TMO) begin
         errors++;
         $display("FAIL tmo_latency got %0d want %0d", t - last_acc_a, TMO);
      end
      checks++;
      if ({error_count_a, fei_a, fee_a, feg_a} !== {16'd6, 16'd9, 8'h19, 8'h1A}) begin
         errors++;
         $display("FAIL tmo_capture got cnt=%0d idx=%0d exp=%h got=%h want 6 9 19 1a",
                  error_count_a, fei_a, fee_a, feg_a);
      end
   endtask

   task automatic test_outstanding;
      int t;
      bit ok;
      set_echo(50, -1, -1);
      pulse_start_a(8'h30);
      repeat (10) @(negedge clk);
      checks++;
      if (tx_valid_a !== 1'b0 || push_a !== MO) begin
         errors++;
         $display("FAIL outst_stall got tx_valid=%b pushes=%0d want 0 %0d", tx_valid_a, push_a, MO);
      end
      pulse_start_a(8'h99);
      wait_done_a(5000, t, ok);
      checks++;
      if (!ok || pass_a !== 1'b1) begin
         errors++;
         $display("FAIL outst_pass got done=%b pass=%b want 1 1", done_a, pass_a);
      end
      checks++;
      if (max_occ_a !== MO) begin
         errors++;
         $display("FAIL outst_max_occ got %0d want %0d", max_occ_a, MO);
      end
      checks++;
      if ({log_a[0], log_a[15]} !== {8'h30, 8'h3F} || push_a !== NB) begin
         errors++;
         $display("FAIL outst_ignore_start got %h %h pushes=%0d want 30 3f %0d",
                  log_a[0], log_a[15], push_a, NB);
      end
   endtask

   task automatic test_back_to_back;
      int t;
      bit ok;
      set_echo(0, -1, -1);
      tx_ready_a = 1'b0;
      pulse_start_a(8'h40);
      repeat (3) @(negedge clk);
      checks++;
      if ({tx_valid_a, busy_a, tx_data_a} !== {1'b1, 1'b1, 8'h40}) begin
         errors++;
         $display("FAIL b2b_hold got valid=%b busy=%b data=%h want 1 1 40", tx_valid_a, busy_a, tx_data_a);
      end
      tx_ready_a = 1'b1;
      wait_done_a(1000, t, ok);
      checks++;
      if (!ok || pass_a !== 1'b1) begin
         errors++;
         $display("FAIL b2b_pass got done=%b pass=%b want 1 1", done_a, pass_a);
      end
      checks++;
      if (last_push_a - first_push_a !== NB - 1) begin
         errors++;
         $display("FAIL b2b_rate got %0d want %0d", last_push_a - first_push_a, NB - 1);
      end
   endtask

   task automatic test_reset_mid_run;
      logic [61:0] obs;
      int t;
      bit ok;
      set_echo(50, -1, -1);
      pulse_start_a(8'h55);
      for (int i = 0; i < 100 && push_a < 3; i++) @(negedge clk);
      checks++;
      if (push_a !== 3) begin
         errors++;
         $display("FAIL midrst_pushes got %0d want 3", push_a);
      end
      rst = 1'b0;
      #1;
      obs = {tx_valid_a, rx_ready_a, busy_a, done_a, pass_a, timeout_a,
             error_count_a, fei_a, feg_a, fee_a, tx_data_a};
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL midrst_outputs got %h want 0", obs);
      end
      @(negedge clk);
      rst = 1'b1;
      set_echo(0, -1, -1);
      pulse_start_a(8'h20);
      wait_done_a(1000, t, ok);
      checks++;
      if (!ok || pass_a !== 1'b1 || {log_a[0], log_a[15]} !== {8'h20, 8'h2F}) begin
         errors++;
         $display("FAIL midrst_rerun got done=%b pass=%b first=%h last=%h want 1 1 20 2f",
                  done_a, pass_a, log_a[0], log_a[15]);
      end
   endtask

   initial begin
      start_a = 1'b0; seed_a = 8'h00; tx_ready_a = 1'b1;
      start_b = 1'b0; seed_b = 8'h00; tx_ready_b = 1'b1;
      set_echo(0, -1, -1);
      test_reset();
      test_incrementing();
      test_wrap();
      test_lfsr();
      test_mismatch();
      test_timeout();
      test_outstanding();
      test_back_to_back();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
